if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Holds the PC and reads each 32-bit instruction over a byte-wide instruction-memory port, one byte per acknowledged request.
- Presents {pc, inst} to decode through a valid/ready handshake and honours pipeline stall and branch/jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, width of PC and memory address

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall_i  input  1  pipeline-control stall; blocks hand-off to decode
branch_flag_i  input  1  redirect request from execute; single-cycle pulse
branch_target_i  input  ADDR_W  redirect target address
mem_req_o  output  1  byte read request to instruction memory
mem_addr_o  output  ADDR_W  byte address of the current request
mem_ack_i  input  1  memory accepts the request; mem_rdata_i valid this cycle
mem_rdata_i  input  8  returned byte
inst_valid_o  output  1  pc_o/inst_o hold a complete instruction
pc_o  output  ADDR_W  address of the presented instruction
inst_o  output  32  presented instruction, little-endian assembled
id_ready_i  input  1  decode accepts the instruction this cycle

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-fetch):
  - pc=RESET_PC; state=F0; byte buffer cleared.
  - Outputs: inst_valid_o=0, inst_o=0, pc_o=RESET_PC, mem_req_o=0, mem_addr_o=RESET_PC.
  - mem_req_o goes high in the first cycle after rst deasserts.
- States: F0, F1, F2, F3 (fetching byte k), HOLD (instruction presented).
- In Fk:
  - mem_req_o=1, mem_addr_o=pc+k (combinational from state and pc, mod 2^ADDR_W).
  - With mem_ack_i=1, mem_rdata_i is stored in inst[8k+7:8k] and the FSM advances to F(k+1).
  - F3+ack moves to HOLD and registers inst_valid_o=1, pc_o=pc.
  - Without ack, the FSM stays in Fk and address and request stay stable.
- In HOLD:
  - mem_req_o=0.
  - Hand-off occurs when inst_valid_o & id_ready_i & !stall_i. On hand-off: pc<=pc+4, inst_valid_o<=0, state<=F0.
  - Otherwise pc_o/inst_o/inst_valid_o hold unchanged.
- stall_i affects only the HOLD hand-off. An in-progress fetch continues to completion while stalled.
- Latency and throughput:
  - With ack every cycle, inst_valid_o rises 4 cycles after the F0 request cycle.
  - With id_ready_i=1 and stall_i=0, one instruction completes every 5 cycles.
- Redirect (branch_flag_i=1 at an edge, any state):
  - pc<={branch_target_i[ADDR_W-1:2],2'b00}; state<=F0; partial bytes discarded; inst_valid_o<=0.
  - A mem_ack_i in the same cycle is ignored.
  - Redirect beats a simultaneous hand-off: pc becomes the target, not pc+4. Decode is responsible for flushing the word it sampled.
- rst beats branch_flag_i.
- PC wrap: 32'hFFFF_FFFC+4 -> 0. Byte addresses wrap likewise.
- inst_o is only meaningful while inst_valid_o=1. It retains its last value otherwise (0 after reset).

Test Plan:
- Reset then fetch: mem acks every cycle returning 13,00,50,00 at addresses 0..3. Required: mem_addr_o=0,1,2,3 on successive cycles; cycle 5 inst_valid_o=1, inst_o=32'h0050_0013, pc_o=0; next request at address 4 after hand-off.
- Memory wait states: ack withheld 3 cycles on byte 2. Required: mem_addr_o=2 and mem_req_o=1 held throughout; final inst_o correct; no duplicated or skipped byte.
- Decode back-pressure/stall: instruction valid while id_ready_i=0 for 4 cycles, then ready=1 with stall_i=1 for 2 cycles. Required: inst_o/pc_o/inst_valid_o stable; no mem_req_o; hand-off only when ready=1 & stall_i=0; pc then 4.
- Redirect mid-fetch: branch_flag_i with target 32'h0000_0103 during F2 (ack also high). Required: next cycle F0 at address 32'h100; the acked byte is discarded; the next instruction presented has pc_o=32'h100.
- Redirect coincident with hand-off at pc=8, target 32'h40. Required: pc becomes 32'h40 (not 12); inst_valid_o=0 next cycle.
- Reset mid-fetch in F3: rst high 1 cycle. Required: inst_valid_o=0, mem_req_o=0 during reset; fetch restarts at RESET_PC from byte 0.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: pipeline control from upstream, the byte-wide
// instruction-memory port, and the valid/ready hand-off to decode.
interface if_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
    logic              id_ready;

    modport master (
        input  stall, branch_flag, branch_target, mem_ack, mem_rdata, id_ready,
        output mem_req, mem_addr, inst_valid, pc, inst
    );

    modport slave (
        output stall, branch_flag, branch_target, mem_ack, mem_rdata, id_ready,
        input  mem_req, mem_addr, inst_valid, pc, inst
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: gathers a 32-bit word one byte per acknowledged request,
// presents {pc, inst} to decode, and honours stall and branch redirect.
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    if_fetch_if.master  bus
);
    typedef enum logic [2:0] {F0, F1, F2, F3, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_out;
    logic [23:0]       byte_buf;
    logic [31:0]       inst_out;
    logic              inst_valid;
    logic [1:0]        byte_idx;
    logic              fetching;
    logic              handoff;
    logic              byte_take;
    logic              last_byte;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= F0;
        else     state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        byte_idx   = 2'd0;
        fetching   = 1'b0;
        handoff    = 1'b0;
        case (state)
            F0: begin
                fetching = 1'b1;
                byte_idx = 2'd0;
                if (bus.mem_ack) state_next = F1;
            end
            F1: begin
                fetching = 1'b1;
                byte_idx = 2'd1;
                if (bus.mem_ack) state_next = F2;
            end
            F2: begin
                fetching = 1'b1;
                byte_idx = 2'd2;
                if (bus.mem_ack) state_next = F3;
            end
            F3: begin
                fetching = 1'b1;
                byte_idx = 2'd3;
                if (bus.mem_ack) state_next = HOLD;
            end
            HOLD: begin
                if (inst_valid && bus.id_ready && !bus.stall) begin
                    handoff    = 1'b1;
                    state_next = F0;
                end
            end
            default: state_next = F0;
        endcase
        // A redirect restarts the fetch no matter what else happens this cycle.
        if (bus.branch_flag) state_next = F0;
    end

    assign byte_take = fetching && bus.mem_ack;
    assign last_byte = byte_take && (state == F3);

    // NOTE: the byte buffer is reset explicitly; it is a handful of flops,
    // not a RAM, so clearing it costs nothing and keeps inst deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            pc_out     <= RESET_PC;
            byte_buf   <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
        end else if (bus.branch_flag) begin
            pc         <= bus.branch_target & ~ADDR_W'(3);
            inst_valid <= 1'b0;
        end else begin
            if (byte_take) begin
                case (byte_idx)
                    2'd0:    byte_buf[7:0]   <= bus.mem_rdata;
                    2'd1:    byte_buf[15:8]  <= bus.mem_rdata;
                    2'd2:    byte_buf[23:16] <= bus.mem_rdata;
                    default: ;
                endcase
            end
            if (last_byte) begin
                inst_out   <= {bus.mem_rdata, byte_buf};
                pc_out     <= pc;
                inst_valid <= 1'b1;
            end
            if (handoff) begin
                pc         <= pc + ADDR_W'(4);
                inst_valid <= 1'b0;
            end
        end
    end

    // Request is masked while reset is held so memory sees nothing until release.
    assign bus.mem_req    = fetching && !rst;
    assign bus.mem_addr   = pc + ADDR_W'(byte_idx);
    assign bus.inst_valid = inst_valid;
    assign bus.pc         = pc_out;
    assign bus.inst       = inst_out;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random traffic, all checked
// against a byte-count reference model of the fetch stage.
module tb_if_fetch;
    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    if_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pc of the word being fetched, bytes gathered so far
    // (4 means a word is being presented), and the presented pc/word.
    logic [31:0] m_pc;
    int          m_cnt;
    logic [7:0]  m_bytes [4];
    logic [31:0] m_inst;
    logic [31:0] m_pcout;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] i;
        i = a[7:0];
        return {mem[8'(i + 8'd3)], mem[8'(i + 8'd2)], mem[8'(i + 8'd1)], mem[i]};
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t,
                         input logic a, input logic rd);
        logic [31:0] ea;
        ea = m_pc + 32'(m_cnt);
        rst               = r;
        bus.stall         = s;
        bus.branch_flag   = b;
        bus.branch_target = t;
        bus.mem_ack       = a;
        bus.id_ready      = rd;
        bus.mem_rdata     = mem[ea[7:0]];
        #1;
        check("mem_req", 32'(bus.mem_req), 32'(!r && m_cnt < 4));
        if (!r && m_cnt < 4) check("mem_addr", bus.mem_addr, ea);
        check("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
        check("pc_o", bus.pc, m_pcout);
        check("inst_o", bus.inst, m_inst);
        if (r) begin
            m_pc = RESET_PC; m_cnt = 0; m_inst = '0; m_pcout = RESET_PC; m_valid = 1'b0;
        end else if (b) begin
            m_pc = {t[31:2], 2'b00}; m_cnt = 0; m_valid = 1'b0;
        end else if (m_cnt < 4) begin
            if (a) begin
                m_bytes[m_cnt] = mem[ea[7:0]];
                m_cnt++;
                if (m_cnt == 4) begin
                    m_inst  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_pcout = m_pc;
                    m_valid = 1'b1;
                end
            end
        end else if (rd && !s) begin
            m_pc = m_pc + 32'd4; m_cnt = 0; m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic acks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
        bus.stall = 1'b0; bus.branch_flag = 1'b0; bus.branch_target = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.id_ready = 1'b0;

        rst = 1'b1;
        @(posedge clk);
        #1;
        m_pc = RESET_PC; m_cnt = 0; m_inst = '0; m_pcout = RESET_PC; m_valid = 1'b0;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_pc", bus.pc, RESET_PC);

        // Reset then back-to-back fetch of the first word.
        acks(4);
        check("tp1_valid", 32'(bus.inst_valid), 32'd1);
        check("tp1_inst", bus.inst, 32'h0050_0013);
        check("tp1_pc", bus.pc, 32'h0);

        // Decode back-pressure, then stall, then hand-off.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("tp3_held", bus.inst, 32'h0050_0013);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("tp3_addr", bus.mem_addr, 32'h4);
        check("tp3_req", 32'(bus.mem_req), 32'd1);

        // Wait states on byte 2.
        acks(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("tp2_addr", bus.mem_addr, 32'h6);
        acks(2);
        check("tp2_inst", bus.inst, word_at(32'h4));
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Redirect coincident with hand-off at pc=8.
        acks(4);
        check("tp5_pc", bus.pc, 32'h8);
        cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        check("tp5_addr", bus.mem_addr, 32'h40);
        check("tp5_valid", 32'(bus.inst_valid), 32'd0);

        // Redirect during F2 with a simultaneous ack.
        acks(2);
        cycle(1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b0);
        check("tp4_addr", bus.mem_addr, 32'h100);
        acks(4);
        check("tp4_pc", bus.pc, 32'h100);
        check("tp4_inst", bus.inst, word_at(32'h100));
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Reset while in F3.
        acks(3);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("tp6_req", 32'(bus.mem_req), 32'd0);
        check("tp6_valid", 32'(bus.inst_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("tp6_addr", bus.mem_addr, RESET_PC);
        check("tp6_req_up", 32'(bus.mem_req), 32'd1);
        acks(4);
        check("tp6_inst", bus.inst, 32'h0050_0013);

        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        acks(4);
        check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("wrap_addr", bus.mem_addr, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, b, a, rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) < 1);
            s  = ($urandom_range(0, 99) < 20);
            b  = ($urandom_range(0, 99) < 4);
            a  = ($urandom_range(0, 99) < 70);
            rd = ($urandom_range(0, 99) < 60);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            cycle(r, s, b, t, a, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
